// File: rtl/mips_pkg.sv
// Shared MIPS core constants and types.
// Includes the instruction-memory loader state encoding.
package mips_pkg;

    localparam int PC_WIDTH    = 32;
    localparam int INSTR_WIDTH = 32;
    localparam int IMEM_DEPTH  = 64;

    // sll $0,$0,0
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        LD_LOAD,
        LD_RUN,
        LD_ERR
    } loader_state_t;

    // Move a partially assembled word to the top, zero-filling the low bytes.
    function automatic logic [31:0] left_justify(
        input logic [31:0] bytes_in,
        input logic [1:0]  last_idx
    );
        return bytes_in << {~last_idx, 3'b000};
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port,
// one asynchronous read port, contents not reset.
module imem_array #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Instruction memory for mips_core, filled by a byte-serial stream
// before the core is released from reset.
module imem_loader
    import mips_pkg::*;
#(
    parameter int DEPTH       = IMEM_DEPTH,
    parameter int PC_WIDTH    = mips_pkg::PC_WIDTH,
    parameter int INSTR_WIDTH = mips_pkg::INSTR_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [7:0]             load_byte,
    input  logic                   load_last,
    input  logic                   reload,
    output logic                   core_run,
    output logic                   load_err,
    input  logic [PC_WIDTH-1:0]    pc,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic                   pc_misalign
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

    loader_state_t state;
    loader_state_t state_n;

    logic [1:0]  byte_cnt;
    logic [AW-1:0] wr_addr;
    logic [AW:0] word_count;
    logic [23:0] word_buf;

    logic accept;
    logic wr_en;
    logic overflow;
    logic [31:0] wr_word;

    logic [AW-1:0] idx;
    logic in_range;
    logic hit;
    logic [INSTR_WIDTH-1:0] rd_word;

    assign load_ready = (state == LD_LOAD);
    assign accept     = load_valid && load_ready;

    // Byte position k of the incoming byte is byte_cnt; shift left-justifies short words.
    assign wr_word = left_justify({word_buf, load_byte}, byte_cnt);

    always_comb begin
        state_n  = state;
        wr_en    = 1'b0;
        overflow = 1'b0;
        if (reload) begin
            state_n = LD_LOAD;
        end else begin
            unique case (state)
                LD_LOAD: begin
                    if (accept) begin
                        if (word_count == FULL) begin
                            overflow = 1'b1;
                            state_n  = LD_ERR;
                        end else begin
                            wr_en = load_last || (byte_cnt == 2'd3);
                            if (load_last) begin
                                state_n = LD_RUN;
                            end
                        end
                    end
                end
                LD_RUN: state_n = LD_RUN;
                LD_ERR: state_n = LD_ERR;
                default: state_n = LD_LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LD_LOAD;
            byte_cnt   <= 2'd0;
            wr_addr    <= '0;
            word_count <= '0;
            word_buf   <= 24'h0;
            core_run   <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            state    <= state_n;
            core_run <= !reload && (state == LD_RUN);
            if (reload) begin
                byte_cnt   <= 2'd0;
                wr_addr    <= '0;
                word_count <= '0;
                load_err   <= 1'b0;
            end else if (overflow) begin
                load_err <= 1'b1;
            end else if (accept) begin
                word_buf <= {word_buf[15:0], load_byte};
                byte_cnt <= load_last ? 2'd0 : byte_cnt + 2'd1;
                if (wr_en) begin
                    wr_addr    <= wr_addr + 1'b1;
                    word_count <= word_count + 1'b1;
                end
            end
        end
    end

    imem_array #(
        .DEPTH (DEPTH),
        .WIDTH (INSTR_WIDTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (INSTR_WIDTH'(wr_word)),
        .raddr (idx),
        .rdata (rd_word)
    );

    // Anything outside the loaded image reads as a NOP.
    assign idx      = pc[AW+1:2];
    assign in_range = ((pc >> (AW + 2)) == '0);
    assign hit      = (state == LD_RUN)
                   && (pc[1:0] == 2'b00)
                   && in_range
                   && ({1'b0, idx} < word_count);

    assign instr       = hit ? rd_word : INSTR_WIDTH'(NOP);
    assign pc_misalign = core_run && (pc[1:0] != 2'b00);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader (DEPTH=4)
// against a byte-list program model.
module tb_imem_loader;
    import mips_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [7:0]  load_byte = 8'h00;
    logic        load_last = 1'b0;
    logic        reload = 1'b0;
    logic        core_run;
    logic        load_err;
    logic [31:0] pc = 32'h0;
    logic [31:0] instr;
    logic        pc_misalign;

    imem_loader #(
        .DEPTH       (DEPTH),
        .PC_WIDTH    (32),
        .INSTR_WIDTH (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_byte   (load_byte),
        .load_last   (load_last),
        .reload      (reload),
        .core_run    (core_run),
        .load_err    (load_err),
        .pc          (pc),
        .instr       (instr),
        .pc_misalign (pc_misalign)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    exp_t sb[$];
    logic probe = 1'b0;
    logic [7:0] prog[$];
    bit model_run = 1'b0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Program image: consecutive groups of 4 bytes, big-endian, zero tail.
    function automatic logic [31:0] model_instr(input logic [31:0] a);
        int wc;
        int p;
        logic [31:0] w;
        wc = (prog.size() + 3) / 4;
        w = 32'h0;
        if (!model_run || a[1:0] != 2'b00 || (a / 4) >= 32'(wc)) return 32'h0;
        for (int k = 0; k < 4; k++) begin
            p = int'(a / 4) * 4 + k;
            w = {w[23:0], (p < prog.size()) ? prog[p] : 8'h00};
        end
        return w;
    endfunction

    exp_t got;
    always @(negedge clk) begin
        if (probe) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL scoreboard: got probe expected queued entry");
            end else begin
                got = sb.pop_front();
                check($sformatf("instr@%h", got.pc), instr, got.instr);
                check($sformatf("misalign@%h", got.pc), 32'(pc_misalign), 32'(got.mis));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            load_valid = 1'b0;
            load_byte  = 8'($urandom);
            load_last  = 1'($urandom);
            step();
        end
        load_last = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last, input int stalls);
        int n;
        idle(stalls);
        load_valid = 1'b1;
        load_byte  = b;
        load_last  = last;
        n = 0;
        forever begin
            @(negedge clk);
            if (load_ready) break;
            n++;
            if (n > 20) begin
                vectors++;
                miscompares++;
                $display("FAIL ready_timeout: got load_ready=0 expected 1");
                break;
            end
        end
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic stream(input bit with_last, input int stalls);
        for (int i = 0; i < prog.size(); i++) begin
            send_byte(prog[i], with_last && (i == prog.size() - 1), stalls);
        end
    endtask

    task automatic probe_pc(input logic [31:0] a);
        exp_t e;
        pc = a;
        e.pc = a;
        e.instr = model_instr(a);
        e.mis = model_run && (a[1:0] != 2'b00);
        sb.push_back(e);
        probe = 1'b1;
        step();
        probe = 1'b0;
    endtask

    task automatic do_reload();
        reload = 1'b1;
        step();
        reload = 1'b0;
        model_run = 1'b0;
        prog.delete();
    endtask

    task automatic set_prog(input logic [31:0] w0, input logic [31:0] w1, input int n);
        logic [63:0] all;
        all = {w0, w1};
        prog.delete();
        for (int i = 0; i < n; i++) prog.push_back(all[63 - 8 * i -: 8]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // Reset state
        @(negedge clk);
        check("rst_load_ready", 32'(load_ready), 32'd1);
        check("rst_core_run", 32'(core_run), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        check("rst_instr", instr, 32'h0);
        step();
        rst = 1'b0;
        step();

        // Two-word program, core_run timing
        set_prog(32'h20080005, 32'h20090007, 8);
        stream(1'b1, 0);
        @(negedge clk);
        check("core_run_edge", 32'(core_run), 32'd0);
        @(negedge clk);
        check("core_run_next", 32'(core_run), 32'd1);
        step();
        model_run = 1'b1;
        probe_pc(32'h0);
        probe_pc(32'h4);
        probe_pc(32'h8);

        // Bytes offered in RUN are ignored
        load_valid = 1'b1;
        load_last  = 1'b1;
        load_byte  = 8'h5A;
        @(negedge clk);
        check("run_ready", 32'(load_ready), 32'd0);
        step();
        step();
        load_valid = 1'b0;
        load_last  = 1'b0;
        probe_pc(32'h0);
        probe_pc(32'h4);

        // Reload drops core_run on the same edge
        do_reload();
        @(negedge clk);
        check("reload_core_run", 32'(core_run), 32'd0);
        check("reload_ready", 32'(load_ready), 32'd1);
        step();

        // Short final word
        set_prog(32'hAABBCCDD, 32'h11220000, 6);
        stream(1'b1, 0);
        idle(2);
        model_run = 1'b1;
        probe_pc(32'h0);
        probe_pc(32'h4);
        probe_pc(32'h8);
        probe_pc(32'h6);
        probe_pc(32'(4 * DEPTH));

        // Overflow: 17 bytes, no last
        do_reload();
        for (int i = 0; i < 17; i++) prog.push_back(8'($urandom));
        stream(1'b0, 0);
        @(negedge clk);
        check("ovf_load_err", 32'(load_err), 32'd1);
        check("ovf_ready", 32'(load_ready), 32'd0);
        check("ovf_core_run", 32'(core_run), 32'd0);
        step();
        model_run = 1'b0;
        probe_pc(32'h0);
        do_reload();
        @(negedge clk);
        check("ovf_clr_err", 32'(load_err), 32'd0);
        check("ovf_clr_ready", 32'(load_ready), 32'd1);
        step();

        // Random programs with stalls
        for (int t = 0; t < 8; t++) begin
            do_reload();
            n = $urandom_range(1, 4 * DEPTH);
            for (int i = 0; i < n; i++) prog.push_back(8'($urandom));
            stream(1'b1, 2);
            idle(2);
            model_run = 1'b1;
            for (int a = 0; a <= 4 * DEPTH + 4; a += 4) probe_pc(32'(a));
            probe_pc(32'($urandom_range(0, 4 * DEPTH)));
            probe_pc(32'($urandom));
        end

        // rst mid-load, then a fresh 4-byte program
        do_reload();
        set_prog(32'h99887766, 32'h0, 3);
        stream(1'b0, 0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_ready", 32'(load_ready), 32'd1);
        check("midrst_core_run", 32'(core_run), 32'd0);
        step();
        rst = 1'b0;
        set_prog(32'h01234567, 32'h0, 4);
        stream(1'b1, 1);
        idle(2);
        model_run = 1'b1;
        probe_pc(32'h0);
        probe_pc(32'h4);

        // reload with a valid byte in the same cycle
        do_reload();
        send_byte(8'h55, 1'b0, 0);
        load_valid = 1'b1;
        load_byte  = 8'hEE;
        reload     = 1'b1;
        step();
        reload     = 1'b0;
        load_valid = 1'b0;
        set_prog(32'hCAFEF00D, 32'h0, 4);
        stream(1'b1, 0);
        idle(2);
        model_run = 1'b1;
        probe_pc(32'h0);
        probe_pc(32'h4);

        idle(2);
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
